apb_slave_mem: RTL and testbench
================================

Name: apb_slave_mem

Overview:
- Parametrised APB4 completer (slave) with an internal byte-addressable register memory.
- Next generation of the team's fixed 32-bit/8-bit-address APB endpoint. Adds generic data/address width, configurable depth, configurable wait states, byte strobes (pstrb), and pslverr on out-of-range or misaligned accesses.
- Sits behind the APB interconnect as the standard target for driver/monitor benches.

Parameters:
- DATA_W, 32: data bus width in bits; must be 8, 16, 32 or 64.
- ADDR_W, 8: byte address width in bits.
- DEPTH, 64: number of DATA_W-bit words; must satisfy DEPTH*(DATA_W/8) <= 2**ADDR_W.
- WAIT_STATES, 0: number of cycles pready is held low in the access phase; range 0..15.

Ports:
- pclk  in  1  APB clock; all logic is rising-edge.
- preset  in  1  reset, asynchronous, active-high.
- psel  in  1  select.
- penable  in  1  enable; marks the access phase.
- pwrite  in  1  1 = write, 0 = read.
- paddr  in  ADDR_W  byte address.
- pwdata  in  DATA_W  write data.
- pstrb  in  DATA_W/8  write byte-lane strobes.
- prdata  out  DATA_W  read data.
- pready  out  1  transfer complete.
- pslverr  out  1  transfer error.

Behaviour:
- Reset:
  - preset=1 asynchronously forces state=IDLE, wait counter=0, latched request fields=0, all memory words=0.
  - Outputs during reset: prdata=0, pready=0, pslverr=0.
  - Reset in the middle of a transfer discards it; no partial write.
- Output timing: outputs are decoded from registered state only; there is no combinational path from any input to any output.
- Addressing:
  - LSB = log2(DATA_W/8).
  - Word index = paddr[ADDR_W-1:LSB].
  - err = (paddr[LSB-1:0] != 0) || (index >= DEPTH). For DATA_W=8 the misalignment term is absent.
- FSM states: IDLE, ACCESS.
- IDLE:
  - On psel=1 and penable=0 at a clock edge, latch pwrite, index, pwdata, pstrb and err.
  - Load cnt=WAIT_STATES.
  - Latch rd_q = mem[index] (0 if err).
  - Go to ACCESS.
  - penable=1 seen in IDLE without a setup phase is ignored; stay in IDLE.
- ACCESS:
  - pready = (cnt==0).
  - While cnt!=0: decrement cnt each cycle.
  - When cnt==0 and psel=1 and penable=1 (completion): if write and !err, mem[index] byte lane b is updated from pwdata_q[8b+7:8b] for every lane with pstrb_q[b]=1; then go to IDLE.
  - psel=0 while in ACCESS (master abort): go to IDLE, no write, no error.
- Data and error outputs:
  - prdata = rd_q only when state==ACCESS, cnt==0, the access is a read, and !err; otherwise prdata=0.
  - pslverr = (state==ACCESS && cnt==0 && err_q).
  - An errored write never modifies memory.
  - pstrb is ignored on reads.
- Latency:
  - WAIT_STATES=0: pready=1 in the first access-phase cycle (zero-wait APB).
  - Otherwise pready rises in access cycle WAIT_STATES+1.
- Back-to-back transfers:
  - A setup phase in the cycle directly after completion is accepted; state is IDLE in that cycle.
  - A read immediately following a write to the same index returns the newly written data.
- Any field changed by the master during ACCESS is ignored; latched values are used.

Decomposition:
- Package apb_pkg holds:
  - typedef enum logic {IDLE, ACCESS} apb_state_e;
  - localparam function clog2-based STRB_W and LSB helpers;
  - the WAIT_STATES counter width constant (4 bits).
- Sub-module apb_regfile: DEPTH x DATA_W byte-enabled write, asynchronous read, async reset to 0. apb_slave_mem instantiates it and contains the FSM, address decode and output logic.

Test Plan:
All scenarios use DATA_W=32, ADDR_W=8, DEPTH=16, WAIT_STATES=2 unless stated.
- Full-word write then read: write paddr=0x04, pwdata=0xDEADBEEF, pstrb=0xF; then read 0x04 -> prdata=0xDEADBEEF, pslverr=0, pready low for exactly 2 access cycles, then high.
- Partial strobe: write 0x04 with pwdata=0x11112222, pstrb=0x3; read 0x04 -> 0xDEAD2222.
- Errors:
  - Write paddr=0x40 (index 16) -> pslverr=1 with pready; read 0x40 -> prdata=0, pslverr=1.
  - Read 0x05 (misaligned) -> pslverr=1.
  - Memory is unchanged after these accesses.
- Back-to-back: write 0x08=0xA5A5A5A5, then read 0x08 with no idle cycle between -> 0xA5A5A5A5. Repeat with WAIT_STATES=0 -> pready high in the first access cycle and each transfer takes 2 cycles.
- Abort: start a write 0x0C=0x12345678 and drop psel during the wait -> FSM returns to IDLE; a later read of 0x0C returns 0x00000000.
- Async reset: assert preset mid-ACCESS, between clock edges -> pready, pslverr and prdata are 0 immediately; after release, read 0x04 -> 0x00000000.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared types and width helpers for the APB completer memory.
package apb_pkg;

  typedef enum logic {
    IDLE,
    ACCESS
  } apb_state_e;

  // Wait-state counter width; holds 0..15.
  localparam int unsigned CNT_W = 4;

  // Number of byte lanes on a DATA_W-bit bus.
  function automatic int unsigned strb_w(input int unsigned data_w);
    return data_w / 8;
  endfunction

  // Number of byte-offset address bits below the word index.
  function automatic int unsigned lsb_w(input int unsigned data_w);
    return $clog2(data_w / 8);
  endfunction

  // Word-index width, at least one bit so a single-word memory still has a port.
  function automatic int unsigned idx_w(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/apb_regfile.sv
// DEPTH x DATA_W storage with byte-enabled write, asynchronous read, async clear.
module apb_regfile
  import apb_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 64
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        we_i,
  input  logic [idx_w(DEPTH)-1:0]     widx_i,
  input  logic [DATA_W-1:0]           wdata_i,
  input  logic [strb_w(DATA_W)-1:0]   wstrb_i,
  input  logic [idx_w(DEPTH)-1:0]     ridx_i,
  output logic [DATA_W-1:0]           rdata_o
);

  localparam int unsigned STRB_W = strb_w(DATA_W);
  localparam int unsigned IDX_W  = idx_w(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Clear every word on reset; otherwise update only the strobed byte lanes.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[IDX_W'(i)] <= '0;
      end
    end else if (we_i) begin
      for (int unsigned b = 0; b < STRB_W; b++) begin
        if (wstrb_i[b]) begin
          mem_q[widx_i][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
    end
  end

  // Read port is combinational; the caller only uses it for in-range indices.
  assign rdata_o = mem_q[ridx_i];

endmodule

// File: rtl/apb_slave_mem.sv
// APB4 completer in front of a byte-addressable register memory, with
// configurable wait states and pslverr on misaligned or out-of-range accesses.
module apb_slave_mem
  import apb_pkg::*;
#(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned DEPTH       = 64,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic                      pclk,
  input  logic                      preset,
  input  logic                      psel,
  input  logic                      penable,
  input  logic                      pwrite,
  input  logic [ADDR_W-1:0]         paddr,
  input  logic [DATA_W-1:0]         pwdata,
  input  logic [strb_w(DATA_W)-1:0] pstrb,
  output logic [DATA_W-1:0]         prdata,
  output logic                      pready,
  output logic                      pslverr
);

  localparam int unsigned STRB_W = strb_w(DATA_W);
  localparam int unsigned LSB    = lsb_w(DATA_W);
  localparam int unsigned IDX_W  = idx_w(DEPTH);

  localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'((1 << LSB) - 1);
  localparam logic [ADDR_W:0]   DEPTH_L    = (ADDR_W + 1)'(DEPTH);
  localparam logic [CNT_W-1:0]  WAIT_L     = CNT_W'(WAIT_STATES);

  apb_state_e state_q, state_d;
  logic [CNT_W-1:0]  cnt_q,   cnt_d;
  logic              wr_q,    wr_d;
  logic [IDX_W-1:0]  idx_q,   idx_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0] strb_q,  strb_d;
  logic              err_q,   err_d;
  logic [DATA_W-1:0] rd_q,    rd_d;

  logic [ADDR_W-1:0] word_c;
  logic [IDX_W-1:0]  idx_c;
  logic              err_c;
  logic              mem_we_c;
  logic [DATA_W-1:0] mem_rdata_c;
  logic              done_c;

  // Address decode of the setup-phase request.
  always_comb begin
    word_c = paddr >> LSB;
    idx_c  = IDX_W'(word_c);
    err_c  = ((paddr & ALIGN_MASK) != '0) || ({1'b0, word_c} >= DEPTH_L);
  end

  apb_regfile #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_regfile (
    .clk_i   (pclk),
    .rst_i   (preset),
    .we_i    (mem_we_c),
    .widx_i  (idx_q),
    .wdata_i (wdata_q),
    .wstrb_i (strb_q),
    .ridx_i  (idx_c),
    .rdata_o (mem_rdata_c)
  );

  // State register and latched request fields.
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      strb_q  <= '0;
      err_q   <= 1'b0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      strb_q  <= strb_d;
      err_q   <= err_d;
      rd_q    <= rd_d;
    end
  end

  // Next-state: latch on setup, count down wait states, commit on completion.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    wr_d     = wr_q;
    idx_d    = idx_q;
    wdata_d  = wdata_q;
    strb_d   = strb_q;
    err_d    = err_q;
    rd_d     = rd_q;
    mem_we_c = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (psel && !penable) begin
          wr_d    = pwrite;
          idx_d   = idx_c;
          wdata_d = pwdata;
          strb_d  = pstrb;
          err_d   = err_c;
          rd_d    = err_c ? '0 : mem_rdata_c;
          cnt_d   = WAIT_L;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (!psel) begin
          state_d = IDLE;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (penable) begin
          mem_we_c = wr_q && !err_q;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded purely from registered state.
  always_comb begin
    done_c  = (state_q == ACCESS) && (cnt_q == '0);
    pready  = done_c;
    pslverr = done_c && err_q;
    prdata  = (done_c && !wr_q && !err_q) ? rd_q : '0;
  end

endmodule

// File: tb/tb_apb_slave_mem.sv
// Directed scoreboard bench: drivers push expected responses, a negedge
// monitor pops and compares each completed transfer.
module tb_apb_slave_mem;

  logic        pclk = 1'b0;
  logic        preset;
  logic        psel, penable, pwrite;
  logic [7:0]  paddr;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic        sel_dut;

  logic        psel0, psel1;
  logic [31:0] prdata0, prdata1, prdata_m;
  logic        pready0, pready1, pready_m;
  logic        pslverr0, pslverr1, pslverr_m;

  always #5 pclk = ~pclk;

  assign psel0     = psel & ~sel_dut;
  assign psel1     = psel & sel_dut;
  assign prdata_m  = sel_dut ? prdata1  : prdata0;
  assign pready_m  = sel_dut ? pready1  : pready0;
  assign pslverr_m = sel_dut ? pslverr1 : pslverr0;

  apb_slave_mem #(.DATA_W(32), .ADDR_W(8), .DEPTH(16), .WAIT_STATES(2)) u_dut0 (
    .pclk(pclk), .preset(preset), .psel(psel0), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
    .prdata(prdata0), .pready(pready0), .pslverr(pslverr0)
  );

  apb_slave_mem #(.DATA_W(32), .ADDR_W(8), .DEPTH(16), .WAIT_STATES(0)) u_dut1 (
    .pclk(pclk), .preset(preset), .psel(psel1), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
    .prdata(prdata1), .pready(pready1), .pslverr(pslverr1)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          waits;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   passed = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Issue one transfer; on return the completion edge has just passed and the
  // bus still holds the old request, so a following call is back-to-back.
  task automatic xfer(input logic wr, input logic [7:0] addr, input logic [31:0] data,
                      input logic [3:0] strb, input logic [31:0] exp_rd, input logic exp_err);
    int n;
    exp_q.push_back('{rdata: exp_rd, err: exp_err, waits: (sel_dut ? 0 : 2)});
    psel    = 1'b1;
    penable = 1'b0;
    pwrite  = wr;
    paddr   = addr;
    pwdata  = data;
    pstrb   = strb;
    @(posedge pclk); #1;
    penable = 1'b1;
    n = 0;
    while (!pready_m && n < 40) begin
      @(posedge pclk); #1;
      n++;
    end
    check32("pready_timeout", 32'(pready_m), 32'd1);
    @(posedge pclk); #1;
  endtask

  task automatic idle();
    psel    = 1'b0;
    penable = 1'b0;
    @(posedge pclk); #1;
  endtask

  // Monitor: count low-pready access cycles, compare on each completion.
  int waits_m = 0;
  always @(negedge pclk) begin
    if (psel && penable && !preset) begin
      if (pready_m) begin
        if (exp_q.size() == 0) begin
          checks++;
          $display("FAIL unexpected_completion: got addr 0x%02h, expected none", paddr);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check32("prdata", prdata_m, e.rdata);
          check32("pslverr", 32'(pslverr_m), 32'(e.err));
          check_int("wait_cycles", waits_m, e.waits);
        end
        waits_m = 0;
      end else begin
        waits_m++;
      end
    end else begin
      waits_m = 0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    time t0;
    int  n;
    preset = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; pstrb = '0; sel_dut = 1'b0;
    #1;
    check32("rst_prdata0", prdata0, 32'h0);
    check32("rst_pready0", 32'(pready0), 32'h0);
    check32("rst_prdata1", prdata1, 32'h0);
    check32("rst_pready1", 32'(pready1), 32'h0);
    @(posedge pclk); @(posedge pclk); #1;
    preset = 1'b0;
    idle();

    // Two-wait-state instance.
    xfer(1, 8'h04, 32'hDEADBEEF, 4'hF, 32'h0, 0);        idle();
    xfer(0, 8'h04, 32'h0,        4'hF, 32'hDEADBEEF, 0); idle();
    xfer(1, 8'h04, 32'h11112222, 4'h3, 32'h0, 0);
    xfer(0, 8'h04, 32'h0,        4'hF, 32'hDEAD2222, 0); idle();
    xfer(1, 8'h40, 32'hFFFFFFFF, 4'hF, 32'h0, 1);
    xfer(0, 8'h40, 32'h0,        4'hF, 32'h0, 1);
    xfer(0, 8'h05, 32'h0,        4'hF, 32'h0, 1);
    xfer(1, 8'h06, 32'hFFFFFFFF, 4'hF, 32'h0, 1);
    xfer(0, 8'h04, 32'h0,        4'h0, 32'hDEAD2222, 0); idle();
    xfer(1, 8'h08, 32'hA5A5A5A5, 4'hF, 32'h0, 0);
    xfer(0, 8'h08, 32'h0,        4'hF, 32'hA5A5A5A5, 0); idle();
    xfer(1, 8'h3C, 32'h13579BDF, 4'hF, 32'h0, 0);
    xfer(0, 8'h3C, 32'h0,        4'hF, 32'h13579BDF, 0); idle();

    // Master abort during the wait phase: no write may land.
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h0C;
    pwdata = 32'h12345678; pstrb = 4'hF;
    @(posedge pclk); #1;
    penable = 1'b1;
    @(posedge pclk); #1;
    idle();
    xfer(0, 8'h0C, 32'h0, 4'hF, 32'h0, 0); idle();

    // Zero-wait-state instance: back-to-back pair takes four cycles.
    sel_dut = 1'b1;
    idle();
    t0 = $time;
    xfer(1, 8'h08, 32'hA5A5A5A5, 4'hF, 32'h0, 0);
    xfer(0, 8'h08, 32'h0,        4'hF, 32'hA5A5A5A5, 0);
    check_int("b2b_zero_wait_time", int'($time - t0), 40);
    xfer(1, 8'h10, 32'h0BADF00D, 4'hC, 32'h0, 0);
    xfer(0, 8'h10, 32'h0,        4'hF, 32'h0BAD0000, 0); idle();

    // Asynchronous reset while a read is presenting data.
    sel_dut = 1'b0;
    idle();
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 8'h04; pstrb = 4'hF;
    @(posedge pclk); #1;
    penable = 1'b1;
    n = 0;
    while (!pready0 && n < 40) begin
      @(posedge pclk); #1;
      n++;
    end
    check32("pre_reset_prdata", prdata0, 32'hDEAD2222);
    #2;
    preset = 1'b1;
    #1;
    check32("async_rst_pready", 32'(pready0), 32'h0);
    check32("async_rst_pslverr", 32'(pslverr0), 32'h0);
    check32("async_rst_prdata", prdata0, 32'h0);
    psel = 1'b0; penable = 1'b0;
    @(posedge pclk); #1;
    preset = 1'b0;
    idle();
    xfer(0, 8'h04, 32'h0, 4'hF, 32'h0, 0); idle();
    sel_dut = 1'b1;
    idle();
    xfer(0, 8'h08, 32'h0, 4'hF, 32'h0, 0); idle();

    idle();
    check_int("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
